// File: rtl/tap_tempo_detector.sv
// Tap-tempo interval detector: measures sample ticks between taps, debounces, times out,
// and averages the last AVG_DEPTH intervals. Optional outlier rejection: TD_OUTLIER_REJECT_EN.
module tap_tempo_detector #(
   parameter int TD_MAX_TIME = 100_000,
   parameter int TD_MIN_TIME = 400,
   parameter int AVG_DEPTH   = 4,
   parameter int DW          = $clog2(TD_MAX_TIME + 1)
) (
   input  logic          clk_i,
   input  logic          srst_i,
   input  logic          sample_tick_i,
   input  logic          trigger_i,
   output logic [DW-1:0] detected_time_o,
   output logic          valid_stb_o,
   output logic          avg_full_o,
   output logic          timeout_stb_o
);

   localparam int LW = $clog2(AVG_DEPTH);
   localparam int FW = LW + 1;
   localparam int SW = DW + LW;
   localparam logic [DW-1:0] MAX_CNT = DW'(TD_MAX_TIME);
   localparam logic [DW-1:0] MIN_CNT = DW'(TD_MIN_TIME);
   localparam logic [FW-1:0] FULL    = FW'(AVG_DEPTH);

   typedef enum logic {IDLE, ARMED} state_t;

   state_t          state, next_state;
   logic [DW-1:0]   cnt, cnt_next;
   logic [FW-1:0]   fill, fill_upd;
   logic [LW-1:0]   ptr;
   logic [SW-1:0]   sum, sum_upd;
   logic [DW-1:0]   evicted;
   logic [DW-1:0]   hist [AVG_DEPTH];
   logic            accept, restart, timeout;
   logic            push, seed;

   function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] c, input logic en);
      return (en && c != MAX_CNT) ? c + DW'(1) : c;
   endfunction

   // Truncating divide by the power-of-two history depth.
   function automatic logic [DW-1:0] avg_of(input logic [SW-1:0] s);
      return DW'(s >> LW);
   endfunction

   // Decision stage: classify the current trigger against the registered counter.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      restart    = 1'b0;
      timeout    = 1'b0;
      case (state)
         IDLE: begin
            if (trigger_i) next_state = ARMED;
         end
         ARMED: begin
            if (trigger_i && cnt > MIN_CNT && cnt < MAX_CNT) begin
               accept = 1'b1;
            end else if (trigger_i && cnt == MAX_CNT) begin
               restart = 1'b1;
            end else if (cnt == MAX_CNT) begin
               timeout    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      cnt_next = sat_inc(cnt, sample_tick_i);
      if (state == IDLE || accept || restart || timeout) cnt_next = '0;
      evicted  = (fill == FULL) ? hist[ptr] : '0;
      sum_upd  = sum + SW'(cnt) - SW'(evicted);
      fill_upd = (fill == FULL) ? fill : fill + FW'(1);
   end

`ifdef TD_OUTLIER_REJECT_EN
   logic          rej;
   logic          outlier, park;
   logic [DW-1:0] avg, dev;

   always_comb begin
      avg     = avg_of(sum);
      dev     = (cnt >= avg) ? cnt - avg : avg - cnt;
      outlier = avg_full_o && (dev > (avg >> 2));
      push    = accept && !outlier;
      park    = accept && outlier && !rej;
      seed    = accept && outlier && rej;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         rej <= 1'b0;
      end else if (restart || timeout || push || seed) begin
         rej <= 1'b0;
      end else if (park) begin
         rej <= 1'b1;
      end
   end
`else
   assign push = accept;
   assign seed = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (srst_i) state <= IDLE;
      else        state <= next_state;
   end

   // Register stage: counter, history bookkeeping and strobed outputs.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         cnt             <= '0;
         fill            <= '0;
         ptr             <= '0;
         sum             <= '0;
         detected_time_o <= '0;
         valid_stb_o     <= 1'b0;
         avg_full_o      <= 1'b0;
         timeout_stb_o   <= 1'b0;
      end else begin
         cnt           <= cnt_next;
         valid_stb_o   <= push | seed;
         timeout_stb_o <= timeout;
         if (restart || timeout) begin
            fill       <= '0;
            ptr        <= '0;
            sum        <= '0;
            avg_full_o <= 1'b0;
         end else if (push) begin
            ptr             <= ptr + LW'(1);
            sum             <= sum_upd;
            fill            <= fill_upd;
            avg_full_o      <= (fill_upd == FULL);
            detected_time_o <= (fill_upd == FULL) ? avg_of(sum_upd) : cnt;
         end else if (seed) begin
            ptr             <= LW'(1);
            sum             <= SW'(cnt);
            fill            <= FW'(1);
            avg_full_o      <= 1'b0;
            detected_time_o <= cnt;
         end
      end
   end

   // History storage carries no reset; fill/ptr define which entries are meaningful.
   always_ff @(posedge clk_i) begin
      if (push)      hist[ptr] <= cnt;
      else if (seed) hist[0]   <= cnt;
   end

endmodule

// File: tb/tb_tap_tempo_detector.sv
// Bench for tap_tempo_detector: directed scenarios plus randomized taps/ticks checked
// every cycle against a queue-based reference model of the tempo rules.
module tb_tap_tempo_detector;

   localparam int MAXT  = 1000;
   localparam int MINT  = 40;
   localparam int DEPTH = 4;
   localparam int DW    = $clog2(MAXT + 1);

   logic          clk_i = 1'b0;
   logic          srst_i;
   logic          sample_tick_i;
   logic          trigger_i;
   logic [DW-1:0] detected_time_o;
   logic          valid_stb_o;
   logic          avg_full_o;
   logic          timeout_stb_o;

   tap_tempo_detector #(
      .TD_MAX_TIME(MAXT),
      .TD_MIN_TIME(MINT),
      .AVG_DEPTH  (DEPTH)
   ) dut (
      .clk_i          (clk_i),
      .srst_i         (srst_i),
      .sample_tick_i  (sample_tick_i),
      .trigger_i      (trigger_i),
      .detected_time_o(detected_time_o),
      .valid_stb_o    (valid_stb_o),
      .avg_full_o     (avg_full_o),
      .timeout_stb_o  (timeout_stb_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Reference model state: armed flag, ticks since last tap, accepted intervals.
   bit m_armed;
   int m_el;
   int m_q[$];
   int m_det;
   bit m_vld, m_to, m_rej;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int qsum();
      int s = 0;
      foreach (m_q[i]) s += m_q[i];
      return s;
   endfunction

   task automatic accept_interval(input int iv);
      m_el = 0;
`ifdef TD_OUTLIER_REJECT_EN
      if (m_q.size() == DEPTH) begin
         int avg = qsum() / DEPTH;
         int dev = (iv > avg) ? iv - avg : avg - iv;
         if (dev > avg / 4) begin
            if (!m_rej) begin
               m_rej = 1;
               return;
            end
            m_q.delete();
            m_q.push_back(iv);
            m_rej = 0;
            m_det = iv;
            m_vld = 1;
            return;
         end
      end
      m_rej = 0;
`endif
      m_q.push_back(iv);
      if (m_q.size() > DEPTH) void'(m_q.pop_front());
      m_det = (m_q.size() == DEPTH) ? qsum() / DEPTH : iv;
      m_vld = 1;
   endtask

   task automatic model_step(input bit rst, input bit trg, input bit tk);
      m_vld = 0;
      m_to  = 0;
      if (rst) begin
         m_armed = 0; m_el = 0; m_q.delete(); m_det = 0; m_rej = 0;
      end else if (!m_armed) begin
         if (trg) begin m_armed = 1; m_el = 0; end
      end else if (trg && m_el > MINT && m_el < MAXT) begin
         accept_interval(m_el);
      end else if (trg && m_el == MAXT) begin
         m_q.delete(); m_rej = 0; m_el = 0;
      end else if (m_el == MAXT) begin
         m_armed = 0; m_to = 1; m_q.delete(); m_rej = 0; m_el = 0;
      end else if (tk) begin
         m_el++;
      end
   endtask

   task automatic step(input bit trg, input bit tk);
      trigger_i     = trg;
      sample_tick_i = tk;
      @(posedge clk_i);
      model_step(srst_i, trg, tk);
      #1;
      check_val("valid_stb",   valid_stb_o,     m_vld);
      check_val("timeout_stb", timeout_stb_o,   m_to);
      check_val("avg_full",    avg_full_o,      m_q.size() == DEPTH);
      check_val("detected",    detected_time_o, m_det);
   endtask

   task automatic tap();
      step(1'b1, 1'b1);
   endtask

   task automatic ticks(input int n);
      repeat (n) step(1'b0, 1'b1);
   endtask

   task automatic do_reset();
      srst_i = 1'b1;
      repeat (3) step(1'b0, 1'b1);
      srst_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      srst_i = 1'b1; trigger_i = 1'b0; sample_tick_i = 1'b0;
      do_reset();
      check_val("reset_det",  detected_time_o, 0);
      check_val("reset_vld",  valid_stb_o,     0);
      check_val("reset_full", avg_full_o,      0);
      check_val("reset_to",   timeout_stb_o,   0);

      // First interval and averaging.
      tap();
      check_val("first_tap_vld", valid_stb_o, 0);
      ticks(100); tap();
      check_val("iv100_vld",  valid_stb_o,     1);
      check_val("iv100_det",  detected_time_o, 100);
      check_val("iv100_full", avg_full_o,      0);
      ticks(104); tap(); check_val("iv104_det", detected_time_o, 104);
      ticks(96);  tap(); check_val("iv96_det",  detected_time_o, 96);
      ticks(100); tap();
      check_val("avg4_det",  detected_time_o, 100);
      check_val("avg4_full", avg_full_o,      1);
      ticks(120); tap(); check_val("avg120_det", detected_time_o, 105);

      // Debounced spurious tap keeps counting.
      do_reset();
      tap(); ticks(30);
      tap(); check_val("spurious_vld", valid_stb_o, 0);
      ticks(69); tap(); check_val("spurious_det", detected_time_o, 100);

      // Timeout after full history, then re-arm.
      do_reset();
      tap();
      repeat (4) begin ticks(100); tap(); end
      check_val("pre_to_full", avg_full_o, 1);
      ticks(1000);
      step(1'b0, 1'b1);
      check_val("to_stb",  timeout_stb_o,   1);
      check_val("to_full", avg_full_o,      0);
      check_val("to_det",  detected_time_o, 100);
      step(1'b0, 1'b1);
      check_val("to_once", timeout_stb_o, 0);
      tap(); check_val("rearm_vld", valid_stb_o, 0);
      ticks(200); tap(); check_val("rearm_det", detected_time_o, 200);

      // Sparse ticks; a tick coinciding with an accepted tap is discarded.
      do_reset();
      step(1'b1, 1'b0);
      for (int k = 1; k <= 801; k++) begin
         step(k == 401 || k == 801, (k % 4) == 1);
         if (k == 401) check_val("sparse_det1", detected_time_o, 100);
         if (k == 801) check_val("sparse_det2", detected_time_o, 99);
      end

      // Reset mid-interval aborts without strobes.
      do_reset();
      tap(); ticks(50);
      srst_i = 1'b1; step(1'b0, 1'b1); srst_i = 1'b0;
      check_val("abort_to", timeout_stb_o, 0);
      ticks(60); tap(); check_val("abort_vld", valid_stb_o, 0);

`ifdef TD_OUTLIER_REJECT_EN
      do_reset();
      tap();
      repeat (4) begin ticks(100); tap(); end
      ticks(200); tap();
      check_val("out1_vld", valid_stb_o, 0);
      ticks(200); tap();
      check_val("out2_vld",  valid_stb_o,     1);
      check_val("out2_det",  detected_time_o, 200);
      check_val("out2_full", avg_full_o,      0);
      ticks(110); tap();
      check_val("out3_det", detected_time_o, 110);
`endif

      // Randomized taps, tick density and occasional resets.
      do_reset();
      for (int i = 0; i < 20000; i++) begin
         srst_i = ($urandom_range(0, 4999) == 0);
         step($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0);
      end
      srst_i = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         step($urandom_range(0, 1499) == 0, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
